// File: rtl/toggle_cover_detect_pkg.sv
// toggle_cover_detect_pkg: shared toggle-coverage types, point-index helpers and popcount
package toggle_cover_detect_pkg;

    // Largest point vector any toggle-cover counter is expected to handle
    localparam int MAX_POINTS = 64;

    typedef enum logic {ARM, ACTIVE} state_e;

    // Rising transition of bit i lands at point i
    function automatic int rise_idx(input int i);
        return i;
    endfunction

    // Falling transition of bit i lands at point width+i
    function automatic int fall_idx(input int width, input int i);
        return width + i;
    endfunction

    function automatic logic [6:0] popcount(input logic [MAX_POINTS-1:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < MAX_POINTS; i++)
            c = c + 7'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/toggle_cover_detect_if.sv
// toggle_cover_detect_if: control/sample inputs and coverage outputs of the toggle detector
interface toggle_cover_detect_if #(
    parameter int WIDTH = 6
);
    localparam int NP    = 2 * WIDTH;
    localparam int CNT_W = $clog2(NP + 1);

    logic             enable;
    logic             clear;
    logic [WIDTH-1:0] sig;
    logic [NP-1:0]    valid;
    logic [NP-1:0]    covered;
    logic [CNT_W-1:0] covered_cnt;
    logic             all_covered;

    modport master (
        output enable, clear, sig,
        input  valid, covered, covered_cnt, all_covered
    );

    modport slave (
        input  enable, clear, sig,
        output valid, covered, covered_cnt, all_covered
    );

endinterface

// File: rtl/toggle_cover_detect_popcount.sv
// cover_popcount: number of set bits in an N-bit point vector
module cover_popcount
    import toggle_cover_detect_pkg::*;
#(
    parameter int N  = 12,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    // Zero-extend into the shared popcount helper
    always_comb cnt_o = CW'(popcount(MAX_POINTS'(vec_i)));

endmodule

// File: rtl/toggle_cover_detect.sv
// toggle_cover_detect: per-bit rise/fall detector with sticky coverage map and count
module toggle_cover_detect
    import toggle_cover_detect_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int ONCE_ONLY = 1,
    parameter int NP        = 2 * WIDTH,
    parameter int CNT_W     = $clog2(NP + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    toggle_cover_detect_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [NP-1:0]    valid_q, valid_d;
    logic [NP-1:0]    covered_q, covered_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             all_q;
    logic [NP-1:0]    hit;
    logic             det;

    // Count lags the map by one edge: it counts the map as currently registered
    cover_popcount #(.N(NP), .CW(CNT_W)) u_pop (
        .vec_i (covered_q),
        .cnt_o (cnt_d)
    );

    // Transition detection and next-state selection; clear drops any coincident toggle
    always_comb begin
        hit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hit[rise_idx(i)]        = bus.sig[i] & ~prev_q[i];
            hit[fall_idx(WIDTH, i)] = ~bus.sig[i] & prev_q[i];
        end
        det       = (state_q == ACTIVE) && bus.enable && !bus.clear;
        state_d   = bus.enable ? ACTIVE : ARM;
        valid_d   = !det ? '0 : (ONCE_ONLY != 0) ? (hit & ~covered_q) : hit;
        covered_d = bus.clear ? '0 : det ? (covered_q | hit) : covered_q;
    end

    // Arm/active state machine with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARM;
            prev_q    <= '0;
            valid_q   <= '0;
            covered_q <= '0;
            cnt_q     <= '0;
            all_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= bus.sig;
            valid_q   <= valid_d;
            covered_q <= covered_d;
            cnt_q     <= cnt_d;
            all_q     <= (cnt_d == CNT_W'(NP));
        end
    end

    assign bus.valid       = valid_q;
    assign bus.covered     = covered_q;
    assign bus.covered_cnt = cnt_q;
    assign bus.all_covered = all_q;

endmodule
